apb_master_arb: RTL and testbench
=================================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of ACCESS cycles before abort (range 1..255).
REQ-004 SHALL have port pclk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port prstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  2  per-requester transfer request; bit i is requester i.
REQ-007 SHALL have port req_ready  output  2  per-requester one-cycle grant/accept pulse.
REQ-008 SHALL have port req_write  input  2  per-requester direction (1=write).
REQ-009 SHALL have port req_addr  input  2*ADDR_WIDTH  per-requester address; requester i occupies slice i.
REQ-010 SHALL have port req_wdata  input  2*DATA_WIDTH  per-requester write data; sliced the same way as req_addr.
REQ-011 SHALL have port rsp_valid  output  2  per-requester one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  error flag; valid with rsp_valid.
REQ-014 SHALL have APB master ports paddr (output, ADDR_WIDTH), psel (output, 1), penable (output, 1), pwrite (output, 1), pwdata (output, DATA_WIDTH), pready (input, 1), prdata (input, DATA_WIDTH), pslverr (input, 1).

Function
REQ-015 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-016 In IDLE with any req_valid bit high, SHALL grant exactly one requester. Grant rules:
- only one requester valid: grant that requester;
- both valid: grant the requester other than last_grant (round-robin).
REQ-017 On grant, SHALL:
- pulse req_ready[i] for that cycle;
- latch addr, wdata and write of requester i;
- set last_grant=i;
- move to SETUP.
REQ-018 SETUP SHALL last exactly one cycle with psel=1 and penable=0, driving the latched paddr, pwrite and pwdata; it then moves to ACCESS.
REQ-019 ACCESS SHALL hold psel=1 and penable=1, with paddr, pwrite and pwdata stable, until pready=1 or timeout.
REQ-020 On pready=1 in ACCESS, the next cycle SHALL:
- pulse rsp_valid[i];
- set rsp_rdata to the sampled prdata for a read, or 0 for a write;
- set rsp_err to the sampled pslverr;
- drive psel=0 and penable=0;
- enter IDLE.
REQ-021 A wait counter SHALL count ACCESS cycles without pready. Timeout behaviour:
- the counter reaching TIMEOUT aborts the transfer;
- the abort ends the transfer as in REQ-020, with rsp_err=1 and rsp_rdata=0;
- the counter clears when not in ACCESS.
REQ-022 pready sampled high in the same cycle the counter reaches TIMEOUT SHALL count as a normal completion (pready wins).
REQ-023 Back-to-back transfers SHALL have at least one IDLE cycle between them, giving a minimum transfer length of 3 cycles from grant to rsp_valid when pready=1 in the first ACCESS cycle.
REQ-024 req_valid changes after grant SHALL NOT affect the transfer in flight; a requester keeps req_valid high until it sees req_ready.
REQ-025 All outputs SHALL be registered, and at most one bit of req_ready or rsp_valid SHALL be high in any cycle.
REQ-026 pready, prdata and pslverr SHALL be ignored outside ACCESS.

Reset
REQ-027 When prstn=0 at a rising edge, SHALL set:
- FSM to IDLE and the counter to 0;
- last_grant=1, so requester 0 wins the first tie;
- psel, penable, pwrite, req_ready, rsp_valid and rsp_err to 0;
- paddr, pwdata and rsp_rdata to 0.
REQ-028 Reset mid-transfer SHALL drop psel and penable at that edge and produce no rsp_valid for the aborted transfer.

Structure
REQ-029 The state encodings (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the requester count (2) SHALL live in shared package apb_pkg, which is also used by the APB bridge.
REQ-030 SHALL contain one sub-module rr_arb2: a combinational two-input round-robin picker taking req[1:0] and last_grant and returning a one-hot grant; all sequencing SHALL stay in apb_master_arb.

Verification
REQ-031 Requester 0 alone writes addr 0x15, data 0xA5, with pready=1 on the first ACCESS cycle -> req_ready[0] at cycle 0; SETUP at cycle 1 (psel=1, penable=0, paddr=0x15, pwdata=0xA5, pwrite=1); ACCESS at cycle 2; rsp_valid[0]=1 and rsp_err=0 at cycle 3.
REQ-032 Requester 1 reads addr 0x24; the slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0x3C -> rsp_valid[1]=1, rsp_rdata=0x3C; penable stays high for exactly 4 cycles.
REQ-033 Both requesters valid continuously for 4 transfers after reset -> grant order 0,1,0,1.
REQ-034 The slave never asserts pready -> rsp_valid with rsp_err=1 and rsp_rdata=0 after TIMEOUT (15) ACCESS cycles; psel=0 the same cycle.
REQ-035 pslverr=1 together with pready=1 on a read -> rsp_err=1, rsp_rdata equals the sampled prdata.
REQ-036 prstn=0 during ACCESS of a pending read -> psel=penable=0 the next cycle, no rsp_valid; the next request after reset is granted normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: phase encodings and requester count, used by the
// arbitrating master and by the APB bridge.
package apb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone requester wins; on a tie the one that
// did not win last time is chosen. Purely combinational, one-hot output.
module rr_arb2
  import apb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_grant_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // NOTE: assigning a default before the case keeps this block latch-free.
  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule : rr_arb2

// File: rtl/apb_master_arb.sv
// Two-requester APB master: arbitrates, runs SETUP/ACCESS with a wait-state
// timeout, and returns a one-cycle response to the granted requester.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                          pclk,
  input  logic                          prstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic                          pready,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pslverr
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  apb_state_e            state_q;
  logic                  last_grant_q;
  logic [CNT_WIDTH-1:0]  wait_cnt_q;
  logic [CNT_WIDTH-1:0]  wait_cnt_d;
  logic [NUM_REQ-1:0]    req_ready_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;

  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_idx;
  logic                  timeout_hit;

  rr_arb2 u_rr_arb2 (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign gnt_idx     = gnt[1];
  assign wait_cnt_d  = wait_cnt_q + CNT_WIDTH'(1);
  assign timeout_hit = (wait_cnt_q == TIMEOUT_LAST);

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, so every register is cleared inside the clocked branch.
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      paddr_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          // A grant pulse was just issued: the following edge opens SETUP.
          if (|req_ready_q) begin
            state_q <= SETUP;
            psel_q  <= 1'b1;
          end else if (|req_valid) begin
            req_ready_q  <= gnt;
            last_grant_q <= gnt_idx;
            pwrite_q     <= req_write[gnt_idx];
            paddr_q      <= gnt_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                    : req_addr[0 +: ADDR_WIDTH];
            pwdata_q     <= gnt_idx ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                    : req_wdata[0 +: DATA_WIDTH];
          end
        end
        SETUP: begin
          wait_cnt_q <= '0;
          state_q    <= ACCESS;
          penable_q  <= 1'b1;
        end
        ACCESS: begin
          // pready takes priority over a timeout landing in the same cycle.
          if (pready || timeout_hit) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= {last_grant_q, ~last_grant_q};
            rsp_err_q   <= pready ? pslverr : 1'b1;
            rsp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: begin
          state_q    <= IDLE;
          psel_q     <= 1'b0;
          penable_q  <= 1'b0;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule : apb_master_arb

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: bus-phase checks inline, responses
// matched against a scoreboard queue filled at grant time.
module tb_apb_master_arb;
  import apb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;

  logic                  pclk = 1'b0;
  logic                  prstn;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;
  logic [AW-1:0]         paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DW-1:0]         pwdata;
  logic                  pready;
  logic [DW-1:0]         prdata;
  logic                  pslverr;

  typedef struct packed {
    logic [NUM_REQ-1:0] vld;
    logic [DW-1:0]      rdata;
    logic               err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  apb_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk      (pclk),
    .prstn     (prstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Response scoreboard: every rsp_valid pulse must match the oldest grant.
  always @(posedge pclk) begin
    #2;
    if (rsp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_vld", 32'(rsp_valid), 32'(e.vld));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Slave idles with pready/pslverr high and junk prdata to show they are
  // ignored outside ACCESS.
  task automatic slave_idle();
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 8'hEE;
  endtask

  task automatic do_reset();
    prstn = 1'b0;
    tick();
    tick();
    prstn = 1'b1;
  endtask

  task automatic do_xfer(input int idx, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int wait_n, input bit to,
                         input logic [DW-1:0] rd, input bit serr, input bit keep);
    logic [NUM_REQ-1:0] exp_g;
    exp_t               e;
    bit                 got;
    int                 n;
    int                 pen;
    exp_g = NUM_REQ'(1 << idx);
    req_valid[idx]          = 1'b1;
    req_write[idx]          = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wd;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = |req_ready;
    end
    check("grant", 32'(req_ready), 32'(exp_g));
    if (!keep) req_valid[idx] = 1'b0;
    e.vld   = exp_g;
    e.rdata = (to || wr) ? '0 : rd;
    e.err   = to ? 1'b1 : serr;
    exp_q.push_back(e);
    tick();
    check("setup_phase", {30'd0, psel, penable}, 32'b10);
    check("setup_paddr", 32'(paddr), 32'(addr));
    check("setup_pwrite", 32'(pwrite), 32'(wr));
    if (wr) check("setup_pwdata", 32'(pwdata), 32'(wd));
    n   = to ? TO : wait_n + 1;
    pen = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      pen += int'(penable);
      check("access_phase", {22'd0, psel, penable, paddr}, {22'd0, 2'b11, addr});
      pready  = !to && (k == wait_n);
      prdata  = rd;
      pslverr = serr;
    end
    tick();
    check("done_bus", {30'd0, psel, penable}, 32'd0);
    check("done_rsp_valid", 32'(rsp_valid), 32'(exp_g));
    check("penable_len", 32'(pen), 32'(n));
    slave_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    slave_idle();
    do_reset();
    check("rst_bus", {27'd0, psel, penable, pwrite, req_ready}, 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_data", {8'd0, paddr, pwdata, rsp_rdata}, 32'd0);

    // Write, zero wait; read with 3 wait states.
    do_xfer(0, 1'b1, 8'h15, 8'hA5, 0, 1'b0, 8'h77, 1'b0, 1'b0);
    do_xfer(1, 1'b0, 8'h24, 8'h00, 3, 1'b0, 8'h3C, 1'b0, 1'b0);
    // Timeout, pready on the last allowed cycle, slave error on a read.
    do_xfer(0, 1'b0, 8'h33, 8'h00, 0, 1'b1, 8'h55, 1'b0, 1'b0);
    do_xfer(1, 1'b0, 8'h44, 8'h00, TO - 1, 1'b0, 8'h5A, 1'b0, 1'b0);
    do_xfer(0, 1'b0, 8'h66, 8'h00, 1, 1'b0, 8'hC3, 1'b1, 1'b0);

    // Reset in the middle of a read's ACCESS phase.
    req_valid[1]      = 1'b1;
    req_write[1]      = 1'b0;
    req_addr[AW +: AW] = 8'h99;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = |req_ready;
    end
    check("mid_grant", 32'(req_ready), 32'b10);
    req_valid[1] = 1'b0;
    pready = 1'b0;
    tick();
    tick();
    tick();
    check("mid_access", {30'd0, psel, penable}, 32'b11);
    prstn = 1'b0;
    tick();
    check("mid_rst_bus", {28'd0, psel, penable, rsp_valid}, 32'd0);
    prstn = 1'b1;
    slave_idle();
    tick();
    tick();
    check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    do_xfer(0, 1'b1, 8'h7E, 8'h18, 0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Both requesters continuously valid after reset: order 0,1,0,1.
    do_reset();
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {8'h82, 8'h81};
    do_xfer(0, 1'b0, 8'h81, 8'h00, 0, 1'b0, 8'h11, 1'b0, 1'b1);
    do_xfer(1, 1'b0, 8'h82, 8'h00, 0, 1'b0, 8'h22, 1'b0, 1'b1);
    do_xfer(0, 1'b0, 8'h83, 8'h00, 0, 1'b0, 8'h33, 1'b0, 1'b0);
    do_xfer(1, 1'b0, 8'h84, 8'h00, 0, 1'b0, 8'h44, 1'b0, 1'b0);

    tick();
    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_apb_master_arb
